// File: rtl/wddl_phase_ctrl.sv
// WDDL precharge/evaluate phase controller.
// Drives a combinational dual-rail datapath through precharge (rails all
// zero) and evaluate (true/complement rails). It captures the dual-rail
// result, checks that every rail pair is complementary, and hands back a
// single-rail result over a valid/ready handshake.
module wddl_phase_ctrl #(
   parameter int unsigned IN_WIDTH    = 40,
   parameter int unsigned OUT_WIDTH   = 8,
   parameter int unsigned PRE_CYCLES  = 1,
   parameter int unsigned EVAL_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   output logic [IN_WIDTH-1:0]  dp_p_out,
   output logic [IN_WIDTH-1:0]  dp_n_out,
   input  logic [OUT_WIDTH-1:0] res_p_in,
   input  logic [OUT_WIDTH-1:0] res_n_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_err,
   output logic                 err_sticky,
   input  logic                 clr_err
);

   localparam int unsigned CNT_MAX = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYCLES - 1);
   localparam logic [CNT_W-1:0] EVAL_LOAD = CNT_W'(EVAL_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRECH = 2'd1,
      EVAL  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IN_WIDTH-1:0]   op_q, op_d;
   logic [IN_WIDTH-1:0]   dp_p_d, dp_n_d;
   logic                  out_valid_d;
   logic [OUT_WIDTH-1:0]  out_data_d;
   logic                  out_err_d;
   logic                  err_sticky_d;
   logic                  pre_fault_q, pre_fault_d;

   assign in_ready = (state_q == IDLE);

   // State, operand, rail and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         dp_p_out    <= '0;
         dp_n_out    <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_err     <= 1'b0;
         err_sticky  <= 1'b0;
         pre_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         dp_p_out    <= dp_p_d;
         dp_n_out    <= dp_n_d;
         out_valid   <= out_valid_d;
         out_data    <= out_data_d;
         out_err     <= out_err_d;
         err_sticky  <= err_sticky_d;
         pre_fault_q <= pre_fault_d;
      end
   end

   // Phase sequencing; rails are the registered next value so they change on
   // the same edge as the state, with rails default-zero outside evaluate.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      dp_p_d       = '0;
      dp_n_d       = '0;
      out_valid_d  = out_valid;
      out_data_d   = out_data;
      out_err_d    = out_err;
      pre_fault_d  = pre_fault_q;
      err_sticky_d = clr_err ? 1'b0 : err_sticky;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = in_data;
               cnt_d   = PRE_LOAD;
               state_d = PRECH;
            end
         end
         PRECH: begin
            if (cnt_q == '0) begin
               // Any rail high during precharge means a stuck or leaking cloud.
               if (|(res_p_in | res_n_in)) begin
                  pre_fault_d = 1'b1;
               end
               cnt_d   = EVAL_LOAD;
               state_d = EVAL;
               dp_p_d  = op_q;
               dp_n_d  = ~op_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         EVAL: begin
            if (cnt_q == '0) begin
               out_data_d  = res_p_in;
               out_err_d   = pre_fault_q | ~(&(res_p_in ^ res_n_in));
               out_valid_d = 1'b1;
               state_d     = DONE;
               // A new error wins over a simultaneous clear.
               if (out_err_d) begin
                  err_sticky_d = 1'b1;
               end
            end else begin
               cnt_d  = cnt_q - CNT_W'(1);
               dp_p_d = op_q;
               dp_n_d = ~op_q;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               pre_fault_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_wddl_phase_ctrl.sv
// Self-checking bench for wddl_phase_ctrl driving a 5-operand x 8-bit WDDL
// XOR datapath model, with randomized operands and fault injection.
module tb_wddl_phase_ctrl;

   localparam int IW  = 40;
   localparam int OW  = 8;
   localparam int PRE = 1;
   localparam int EVL = 2;
   localparam int LAT = PRE + EVL + 1;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] in_data;
   logic [IW-1:0] dp_p_out;
   logic [IW-1:0] dp_n_out;
   logic [OW-1:0] res_p_in;
   logic [OW-1:0] res_n_in;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic          out_err;
   logic          err_sticky;
   logic          clr_err;

   logic          inj_eval;
   logic          inj_pre;
   logic          exp_sticky;
   int            n_cmp;
   int            n_bad;

   wddl_phase_ctrl #(
      .IN_WIDTH   (IW),
      .OUT_WIDTH  (OW),
      .PRE_CYCLES (PRE),
      .EVAL_CYCLES(EVL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .dp_p_out  (dp_p_out),
      .dp_n_out  (dp_n_out),
      .res_p_in  (res_p_in),
      .res_n_in  (res_n_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .err_sticky(err_sticky),
      .clr_err   (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Gate-level WDDL xor5 cloud: each xor2 is p=(ap&bn)|(an&bp), n=(ap&bp)|(an&bn).
   logic [OW-1:0] ap, an, bp, bn, tp, tn;
   always_comb begin
      ap = dp_p_out[7:0];
      an = dp_n_out[7:0];
      bp = '0;
      bn = '0;
      tp = '0;
      tn = '0;
      for (int k = 1; k < 5; k++) begin
         bp = dp_p_out[8*k +: 8];
         bn = dp_n_out[8*k +: 8];
         tp = (ap & bn) | (an & bp);
         tn = (ap & bp) | (an & bn);
         ap = tp;
         an = tn;
      end
      res_p_in = ap;
      res_n_in = an;
      if (inj_pre && ((dp_p_out | dp_n_out) == '0)) res_p_in[0] = 1'b1;
      if (inj_eval && ((dp_p_out | dp_n_out) != '0)) res_n_in[3] = res_p_in[3];
   end

   function automatic logic [OW-1:0] ref_xor(input logic [IW-1:0] op);
      logic [OW-1:0] r;
      r = '0;
      for (int i = 0; i < 5; i++) r = r ^ op[8*i +: 8];
      return r;
   endfunction

   function automatic logic [IW-1:0] rnd_op();
      return IW'({$urandom(), $urandom()});
   endfunction

   // One transaction from an idle DUT, checking rails cycle by cycle, the
   // result, and optional backpressure for 'hold' cycles.
   task automatic do_txn(input logic [IW-1:0] op, input bit f_eval, input bit f_pre,
                         input bit clr_last, input int hold, input string tag);
      logic [OW-1:0] d0;
      logic          e0;
      logic          exp_err;
      exp_err   = f_eval | f_pre;
      inj_eval  = f_eval;
      inj_pre   = f_pre;
      out_ready = (hold == 0);
      in_valid  = 1'b1;
      in_data   = op;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s in_ready_idle: got %b want 1", tag, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         in_data = rnd_op();
         if (k <= PRE || k == LAT) begin
            n_cmp++;
            if (dp_p_out !== '0 || dp_n_out !== '0) begin
               n_bad++;
               $display("FAIL %s rails_zero k=%0d: got p=%h n=%h want 0", tag, k, dp_p_out, dp_n_out);
            end
         end else begin
            n_cmp++;
            if (dp_p_out !== op || dp_n_out !== ~op) begin
               n_bad++;
               $display("FAIL %s rails_eval k=%0d: got p=%h n=%h want p=%h n=%h", tag, k, dp_p_out, dp_n_out, op, ~op);
            end
         end
         n_cmp++;
         if (out_valid !== (k == LAT) || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s latency k=%0d: got valid=%b ready=%b want valid=%b ready=0", tag, k, out_valid, in_ready, (k == LAT));
         end
         if (clr_last && k == PRE + EVL) clr_err = 1'b1;
         else clr_err = 1'b0;
         if (k < LAT) @(negedge clk);
      end
      clr_err = 1'b0;
      exp_sticky = exp_err ? 1'b1 : (clr_last ? 1'b0 : exp_sticky);
      n_cmp++;
      if (out_data !== ref_xor(op) || out_err !== exp_err) begin
         n_bad++;
         $display("FAIL %s result: got data=%h err=%b want data=%h err=%b", tag, out_data, out_err, ref_xor(op), exp_err);
      end
      n_cmp++;
      if (err_sticky !== exp_sticky) begin
         n_bad++;
         $display("FAIL %s err_sticky: got %b want %b", tag, err_sticky, exp_sticky);
      end
      d0 = out_data;
      e0 = out_err;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = rnd_op();
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== d0 || out_err !== e0 || in_ready !== 1'b0 ||
             dp_p_out !== '0 || dp_n_out !== '0) begin
            n_bad++;
            $display("FAIL %s backpressure h=%0d: got valid=%b data=%h err=%b ready=%b p=%h n=%h want 1 %h %b 0 0 0",
                     tag, h, out_valid, out_data, out_err, in_ready, dp_p_out, dp_n_out, d0, e0);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      inj_eval = 1'b0;
      inj_pre  = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s release: got valid=%b ready=%b want valid=0 ready=1", tag, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if (in_ready !== 1'b1 || dp_p_out !== '0 || dp_n_out !== '0 || out_valid !== 1'b0 ||
          out_data !== '0 || out_err !== 1'b0 || err_sticky !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: got ready=%b p=%h n=%h valid=%b data=%h err=%b sticky=%b want 1 0 0 0 0 0 0",
                  in_ready, dp_p_out, dp_n_out, out_valid, out_data, out_err, err_sticky);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      do_txn({8'h81, 8'hF0, 8'h0F, 8'h3C, 8'hA5}, 1'b0, 1'b0, 1'b0, 0, "xor5_fixed");
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         do_txn(rnd_op(), 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 3)), "random");
      end
   endtask

   task automatic test_back_to_back();
      logic [IW-1:0] ops [3];
      logic [OW-1:0] expq [$];
      logic [IW-1:0] prev_p;
      int            idx;
      int            got;
      int            last_acc;
      int            zrun;
      bit            done;
      for (int i = 0; i < 3; i++) ops[i] = rnd_op();
      idx      = 0;
      got      = 0;
      last_acc = -1;
      zrun     = PRE;
      prev_p   = '0;
      done     = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         in_valid = (idx < 3);
         in_data  = (idx < 3) ? ops[idx] : rnd_op();
         if ((dp_p_out & dp_n_out) != '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b2b rail_overlap cyc=%0d: got p&n=%h want 0", cyc, dp_p_out & dp_n_out);
         end
         if (dp_p_out != '0 || dp_n_out != '0) begin
            if (prev_p == '0 && zrun < PRE) begin
               n_cmp++;
               n_bad++;
               $display("FAIL b2b precharge_gap cyc=%0d: got %0d zero cycles want >=%0d", cyc, zrun, PRE);
            end
            if (prev_p != '0 && prev_p !== dp_p_out) begin
               n_cmp++;
               n_bad++;
               $display("FAIL b2b eval_to_eval cyc=%0d: got %h after %h want zero rails between", cyc, dp_p_out, prev_p);
            end
            zrun = 0;
         end else begin
            zrun++;
         end
         prev_p = dp_p_out;
         if (out_valid === 1'b1) begin
            n_cmp++;
            if (expq.size() == 0) begin
               n_bad++;
               $display("FAIL b2b extra_result: got %h want none", out_data);
            end else if (out_data !== expq[0] || out_err !== 1'b0) begin
               n_bad++;
               $display("FAIL b2b result%0d: got data=%h err=%b want data=%h err=0", got, out_data, out_err, expq[0]);
            end
            if (expq.size() != 0) void'(expq.pop_front());
            got++;
            if (got == 3) done = 1'b1;
         end
         if (in_ready === 1'b1 && idx < 3) begin
            if (last_acc >= 0) begin
               n_cmp++;
               if (cyc - last_acc != PRE + EVL + 2) begin
                  n_bad++;
                  $display("FAIL b2b accept_period: got %0d want %0d", cyc - last_acc, PRE + EVL + 2);
               end
            end
            last_acc = cyc;
            expq.push_back(ref_xor(ops[idx]));
            idx++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL b2b timeout: got %0d results want 3", got);
      end
      @(negedge clk);
   endtask

   task automatic test_fault();
      do_txn(rnd_op(), 1'b1, 1'b0, 1'b0, 0, "eval_fault");
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      exp_sticky = 1'b0;
      n_cmp++;
      if (err_sticky !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_err: got %b want 0", err_sticky);
      end
      do_txn(rnd_op(), 1'b0, 1'b0, 1'b0, 0, "clean_after_clr");
      do_txn(rnd_op(), 1'b1, 1'b0, 1'b1, 0, "fault_vs_clr");
      do_txn(rnd_op(), 1'b0, 1'b0, 1'b0, 2, "clean_sticky_held");
   endtask

   task automatic test_pre_fault();
      do_txn(rnd_op(), 1'b0, 1'b1, 1'b0, 0, "pre_fault");
      do_txn(rnd_op(), 1'b0, 1'b0, 1'b0, 0, "pre_fault_cleared");
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1;
      in_data  = rnd_op();
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 1; k <= PRE; k++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (dp_p_out !== '0 || dp_n_out !== '0 || out_valid !== 1'b0 || err_sticky !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_mid: got p=%h n=%h valid=%b sticky=%b ready=%b want 0 0 0 0 1",
                  dp_p_out, dp_n_out, out_valid, err_sticky, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_sticky = 1'b0;
      @(negedge clk);
      do_txn(rnd_op(), 1'b0, 1'b0, 1'b0, 0, "after_reset");
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b1;
      clr_err    = 1'b0;
      inj_eval   = 1'b0;
      inj_pre    = 1'b0;
      exp_sticky = 1'b0;
      test_reset();
      test_single();
      test_random();
      test_back_to_back();
      test_fault();
      test_pre_fault();
      do_txn(rnd_op(), 1'b1, 1'b0, 1'b0, 0, "set_sticky");
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
